// File: rtl/ti_adc_collector.sv
// -----------------------------------------------------------------------------
// ti_adc_collector
//
// Purpose:
//   Collects the per-way SAR results of ADC_WAYS time-interleaved sub-ADCs into
//   one parallel frame in the core_clk domain. A frame is complete once every
//   way has reported since the last frame. Completed frames go into a small
//   FIFO that is drained through a valid/ready handshake. The block also
//   flags a way that reports twice within one frame and counts frames lost
//   because the FIFO was full.
//
// Optional feature (compile-time macro TI_COLLECT_OFFSET_EN):
//   Adds a per-way signed offset table. Each captured sample becomes
//   clamp(raw - offset, 0, 2^ADC_BITS-1). This adds no latency.
//
// Ports:
//   core_clk   in   single clock; every port is synchronous to it
//   rst        in   synchronous, active-high reset
//   way_data   in   per-way results, way i at [i*ADC_BITS +: ADC_BITS]
//   way_done   in   one-cycle per-way done pulses (already in core_clk domain)
//   out_data   out  FIFO head frame, way 0 in the LSBs; holds when empty
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes the head when out_valid & out_ready
//   frame_err  out  sticky flag: a way completed twice within one frame
//   ovf_cnt    out  saturating count of frames dropped on a full FIFO
//   clr_err    in   clears frame_err and ovf_cnt
//   ofs_we     in   (TI_COLLECT_OFFSET_EN) offset table write enable
//   ofs_addr   in   (TI_COLLECT_OFFSET_EN) way index to write
//   ofs_wdata  in   (TI_COLLECT_OFFSET_EN) signed offset, ADC_BITS+1 bits
// -----------------------------------------------------------------------------
module ti_adc_collector #(
    parameter int ADC_WAYS     = 8,
    parameter int ADC_BITS     = 9,
    parameter int FIFO_DEPTH   = 2,
    parameter int OVF_CNT_BITS = 8
) (
    input  logic                         core_clk,
    input  logic                         rst,
    input  logic [ADC_WAYS*ADC_BITS-1:0] way_data,
    input  logic [ADC_WAYS-1:0]          way_done,
`ifdef TI_COLLECT_OFFSET_EN
    input  logic                         ofs_we,
    input  logic [$clog2(ADC_WAYS)-1:0]  ofs_addr,
    input  logic [ADC_BITS:0]            ofs_wdata,
`endif
    output logic [ADC_WAYS*ADC_BITS-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err,
    output logic [OVF_CNT_BITS-1:0]      ovf_cnt,
    input  logic                         clr_err
);

    localparam int DW = ADC_WAYS * ADC_BITS;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADC_WAYS-1:0] mask;
    logic [DW-1:0]       cap;
    logic [DW-1:0]       merged;
    logic                complete;
    logic                dup;

    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic [PW-1:0]       rd_next;
    logic [DW-1:0]       head_next;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

`ifdef TI_COLLECT_OFFSET_EN
    localparam int AW = $clog2(ADC_WAYS);

    logic [ADC_BITS:0] ofs [ADC_WAYS];

    // Offset table. A capture in the same cycle as a write to that way still
    // sees the old offset, because the table is read before this edge.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            for (int i = 0; i < ADC_WAYS; i++) begin
                ofs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ADC_WAYS; i++) begin
                if (ofs_we && (ofs_addr == AW'(i))) begin
                    ofs[i] <= ofs_wdata;
                end
            end
        end
    end
`endif

    // Per-way sample path: the value to store this cycle, and the merged frame
    // in which this cycle's new samples replace the held captures.
    for (genvar g = 0; g < ADC_WAYS; g++) begin : g_way
        logic [ADC_BITS-1:0] raw;
        logic [ADC_BITS-1:0] val;

        assign raw = way_data[g*ADC_BITS +: ADC_BITS];

`ifdef TI_COLLECT_OFFSET_EN
        // Two extra bits hold the full range of raw - offset. The top bit is
        // the sign. If the sign is clear, the next bit marks an overflow.
        logic [ADC_BITS+1:0] diff;

        assign diff = {2'b00, raw} - {ofs[g][ADC_BITS], ofs[g]};

        always_comb begin
            val = diff[ADC_BITS-1:0];
            if (diff[ADC_BITS+1]) begin
                val = '0;
            end else if (diff[ADC_BITS]) begin
                val = '1;
            end
        end
`else
        assign val = raw;
`endif

        assign merged[g*ADC_BITS +: ADC_BITS] = way_done[g] ? val : cap[g*ADC_BITS +: ADC_BITS];
    end

    assign complete = &(mask | way_done);
    assign dup      = |(way_done & mask);

    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = out_valid & out_ready;
    // When the FIFO is full, a push is accepted only if a pop in the same
    // cycle frees a slot.
    assign push_ok = complete & (~full | pop);
    assign drop    = complete & full & ~pop;

    // Next FIFO occupancy and next head. If the pushed frame lands in the slot
    // that becomes the head, it has to be forwarded from the merged frame,
    // because the memory is not written until this edge.
    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count - CW'(1);
        end

        rd_next = pop ? (rd_ptr + PW'(1)) : rd_ptr;

        head_next = mem[rd_next];
        if (push_ok && (rd_next == wr_ptr)) begin
            head_next = merged;
        end
    end

    // The FIFO storage is not reset. Data is only read at slots the pointers
    // mark as filled.
    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= merged;
        end
    end

    // Frame assembly, FIFO pointers, registered output stage and error state.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            mask      <= '0;
            cap       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            cap  <= merged;
            mask <= complete ? '0 : (mask | way_done);

            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;

            out_valid <= (count_next != '0);
            if (count_next != '0) begin
                out_data <= head_next;
            end

            // An error or drop in the same cycle as clr_err takes priority.
            if (dup) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end

            if (drop) begin
                if (clr_err) begin
                    ovf_cnt <= OVF_CNT_BITS'(1);
                end else if (ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + OVF_CNT_BITS'(1);
                end
            end else if (clr_err) begin
                ovf_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ti_adc_collector.sv
// -----------------------------------------------------------------------------
// tb_ti_adc_collector
//
// Self-checking bench for ti_adc_collector with the default parameters.
// A behavioural model tracks which ways have reported and holds the captured
// samples, and it keeps the FIFO as a queue of whole frames. The DUT outputs
// are compared with the model after every clock. The directed sequences also
// check constant expected values for the corner cases. When
// TI_COLLECT_OFFSET_EN is defined, the bench drives the offset port and
// applies the offset-and-clamp rule in its model.
// -----------------------------------------------------------------------------
module tb_ti_adc_collector;

    localparam int WAYS  = 8;
    localparam int BITS  = 9;
    localparam int DEPTH = 2;
    localparam int OCB   = 8;
    localparam int DW    = WAYS * BITS;
    localparam int MAXV  = (1 << BITS) - 1;
    localparam int MAXO  = (1 << OCB) - 1;

    logic            core_clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   way_data;
    logic [WAYS-1:0] way_done;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            frame_err;
    logic [OCB-1:0]  ovf_cnt;
    logic            clr_err;
`ifdef TI_COLLECT_OFFSET_EN
    logic            ofs_we;
    logic [2:0]      ofs_addr;
    logic [BITS:0]   ofs_wdata;
`endif

    always #5 core_clk = ~core_clk;

    ti_adc_collector #(
        .ADC_WAYS     (WAYS),
        .ADC_BITS     (BITS),
        .FIFO_DEPTH   (DEPTH),
        .OVF_CNT_BITS (OCB)
    ) dut (
        .core_clk  (core_clk),
        .rst       (rst),
        .way_data  (way_data),
        .way_done  (way_done),
`ifdef TI_COLLECT_OFFSET_EN
        .ofs_we    (ofs_we),
        .ofs_addr  (ofs_addr),
        .ofs_wdata (ofs_wdata),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .ovf_cnt   (ovf_cnt),
        .clr_err   (clr_err)
    );

    int    compared   = 0;
    int    mismatched = 0;
    string tag        = "init";

    // Behavioural model state
    int            m_cap  [WAYS];
    bit            m_seen [WAYS];
    int            m_ofs  [WAYS];
    logic [DW-1:0] m_q    [$];
    logic [DW-1:0] m_last;
    bit            m_err;
    int            m_ovf;

    typedef struct {
        logic [WAYS-1:0] done;
        logic [BITS-1:0] val;
        logic            exp_valid;
        logic            exp_err;
    } vec_t;

    vec_t tbl [8];

    // Compares one value with its expected value and records the result.
    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Applies the rules to the inputs present at the coming clock edge.
    function automatic void model_step();
        bit            pop;
        bit            dup;
        bit            drop;
        bit            all_seen;
        logic [DW-1:0] frame;
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                m_cap[i]  = 0;
                m_seen[i] = 0;
                m_ofs[i]  = 0;
            end
            m_q.delete();
            m_last = '0;
            m_err  = 0;
            m_ovf  = 0;
            return;
        end
        pop  = (m_q.size() != 0) && out_ready;
        dup  = 0;
        drop = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (way_done[i]) begin
                int v;
                if (m_seen[i]) dup = 1;
                v = int'(way_data[i*BITS +: BITS]);
`ifdef TI_COLLECT_OFFSET_EN
                v = v - m_ofs[i];
                if (v < 0) v = 0;
                if (v > MAXV) v = MAXV;
`endif
                m_cap[i]  = v;
                m_seen[i] = 1;
            end
        end
        all_seen = 1;
        for (int i = 0; i < WAYS; i++) begin
            if (!m_seen[i]) all_seen = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (all_seen) begin
            for (int i = 0; i < WAYS; i++) begin
                frame[i*BITS +: BITS] = BITS'(m_cap[i]);
                m_seen[i] = 0;
            end
            if (m_q.size() < DEPTH) m_q.push_back(frame);
            else drop = 1;
        end
        if (dup) m_err = 1;
        else if (clr_err) m_err = 0;
        if (drop) m_ovf = clr_err ? 1 : ((m_ovf < MAXO) ? m_ovf + 1 : m_ovf);
        else if (clr_err) m_ovf = 0;
`ifdef TI_COLLECT_OFFSET_EN
        if (ofs_we) m_ofs[ofs_addr] = int'($signed(ofs_wdata));
`endif
        if (m_q.size() != 0) m_last = m_q[0];
    endfunction

    // One clock: update the model, pass the edge, then compare away from it.
    task automatic tick();
        model_step();
        @(posedge core_clk);
        @(negedge core_clk);
        checkOutput({tag, "/valid"}, DW'(out_valid), DW'(m_q.size() != 0));
        checkOutput({tag, "/data"},  out_data, m_last);
        checkOutput({tag, "/err"},   DW'(frame_err), DW'(m_err));
        checkOutput({tag, "/ovf"},   DW'(ovf_cnt), DW'(m_ovf));
    endtask

    task automatic applyStimulus(input logic [WAYS-1:0] done, input logic [DW-1:0] data,
                                 input logic ready, input logic clr);
        way_done  = done;
        way_data  = data;
        out_ready = ready;
        clr_err   = clr;
        tick();
    endtask

    task automatic send_way(input int w, input logic [BITS-1:0] v, input logic ready);
        logic [DW-1:0] d;
        d = rand_word();
        d[w*BITS +: BITS] = v;
        applyStimulus(WAYS'(1 << w), d, ready, 1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        way_done  = '0;
        way_data  = rand_word();
        out_ready = 1'b0;
        clr_err   = 1'b0;
`ifdef TI_COLLECT_OFFSET_EN
        ofs_we    = 1'b0;
        ofs_addr  = '0;
        ofs_wdata = '0;
`endif
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] exp_frame;
        logic [DW-1:0] fa, fb, fc;

        for (int i = 0; i < 8; i++) begin
            tbl[i].done      = WAYS'(1 << i);
            tbl[i].val       = BITS'(16 + i);
            tbl[i].exp_valid = (i == 7);
            tbl[i].exp_err   = 1'b0;
        end

        // Reset state
        tag = "reset";
        do_reset();
        checkOutput("reset_valid", DW'(out_valid), '0);
        checkOutput("reset_data",  out_data, '0);
        checkOutput("reset_err",   DW'(frame_err), '0);
        checkOutput("reset_ovf",   DW'(ovf_cnt), '0);

        // One way per cycle, frame available the cycle after the last way
        tag = "t1";
        for (int i = 0; i < 8; i++) begin
            d = rand_word();
            for (int w = 0; w < WAYS; w++) begin
                if (tbl[i].done[w]) d[w*BITS +: BITS] = tbl[i].val;
            end
            applyStimulus(tbl[i].done, d, 1'b0, 1'b0);
            checkOutput($sformatf("t1_valid_%0d", i), DW'(out_valid), DW'(tbl[i].exp_valid));
            checkOutput($sformatf("t1_err_%0d", i),   DW'(frame_err), DW'(tbl[i].exp_err));
        end
        for (int w = 0; w < WAYS; w++) exp_frame[w*BITS +: BITS] = BITS'(16 + w);
        checkOutput("t1_frame", out_data, exp_frame);

        // Three frames into a two-deep FIFO: the third is dropped
        tag = "t2";
        do_reset();
        fa = rand_word(); fb = rand_word(); fc = rand_word();
        applyStimulus('1, fa, 1'b0, 1'b0);
        applyStimulus('1, fb, 1'b0, 1'b0);
        applyStimulus('1, fc, 1'b0, 1'b0);
        checkOutput("t2_head0", out_data, fa);
        checkOutput("t2_ovf",   DW'(ovf_cnt), DW'(1));
        applyStimulus('0, rand_word(), 1'b1, 1'b0);
        checkOutput("t2_head1",  out_data, fb);
        checkOutput("t2_valid1", DW'(out_valid), DW'(1));
        applyStimulus('0, rand_word(), 1'b1, 1'b0);
        checkOutput("t2_empty", DW'(out_valid), '0);
        checkOutput("t2_hold",  out_data, fb);

        // Full FIFO with push and pop in the same cycle
        tag = "t3";
        do_reset();
        fa = rand_word(); fb = rand_word(); fc = rand_word();
        applyStimulus('1, fa, 1'b0, 1'b0);
        applyStimulus('1, fb, 1'b0, 1'b0);
        applyStimulus('1, fc, 1'b1, 1'b0);
        checkOutput("t3_head", out_data, fb);
        checkOutput("t3_ovf",  DW'(ovf_cnt), '0);
        applyStimulus('0, rand_word(), 1'b1, 1'b0);
        checkOutput("t3_head2", out_data, fc);
        applyStimulus('0, rand_word(), 1'b1, 1'b0);
        checkOutput("t3_empty", DW'(out_valid), '0);

        // Duplicate way inside one frame
        tag = "t4";
        do_reset();
        send_way(0, 9'h001, 1'b0);
        send_way(1, 9'h002, 1'b0);
        send_way(2, 9'h003, 1'b0);
        send_way(3, 9'h0AA, 1'b0);
        checkOutput("t4_err_before", DW'(frame_err), '0);
        send_way(4, 9'h005, 1'b0);
        send_way(3, 9'h155, 1'b0);
        checkOutput("t4_err_set", DW'(frame_err), DW'(1));
        send_way(5, 9'h006, 1'b0);
        send_way(6, 9'h007, 1'b0);
        send_way(7, 9'h008, 1'b0);
        checkOutput("t4_valid",  DW'(out_valid), DW'(1));
        checkOutput("t4_way3",   DW'(out_data[3*BITS +: BITS]), DW'(9'h155));
        applyStimulus('0, rand_word(), 1'b0, 1'b1);
        checkOutput("t4_err_clr", DW'(frame_err), '0);

        // Reset in the middle of a partial frame discards it
        tag = "t5";
        do_reset();
        for (int w = 0; w < 5; w++) send_way(w, BITS'(w + 1), 1'b0);
        do_reset();
        for (int w = 5; w < 8; w++) send_way(w, BITS'(w + 1), 1'b0);
        checkOutput("t5_no_frame", DW'(out_valid), '0);
        for (int w = 0; w < 8; w++) send_way(w, BITS'(w + 32), 1'b0);
        checkOutput("t5_frame", DW'(out_valid), DW'(1));
        applyStimulus('0, rand_word(), 1'b1, 1'b0);
        checkOutput("t5_only_one", DW'(out_valid), '0);

        // Drop counter saturation and priority over clr_err
        tag = "t7";
        do_reset();
        for (int k = 0; k < DEPTH + 300; k++) applyStimulus('1, rand_word(), 1'b0, 1'b0);
        checkOutput("t7_sat", DW'(ovf_cnt), DW'(MAXO));
        applyStimulus('1, rand_word(), 1'b0, 1'b1);
        checkOutput("t7_clr_drop", DW'(ovf_cnt), DW'(1));
        applyStimulus('0, rand_word(), 1'b0, 1'b1);
        checkOutput("t7_clr", DW'(ovf_cnt), '0);
        do_reset();
        send_way(0, 9'h011, 1'b0);
        way_done = 8'h01;
        clr_err  = 1'b1;
        applyStimulus(8'h01, rand_word(), 1'b0, 1'b1);
        checkOutput("t7_err_wins", DW'(frame_err), DW'(1));

`ifdef TI_COLLECT_OFFSET_EN
        // Offset subtraction with clamping at both ends
        tag = "t6";
        do_reset();
        ofs_we = 1'b1; ofs_addr = 3'd2; ofs_wdata = 10'd5;
        applyStimulus('0, rand_word(), 1'b0, 1'b0);
        ofs_addr = 3'd5; ofs_wdata = 10'h3FD;
        applyStimulus('0, rand_word(), 1'b0, 1'b0);
        ofs_we = 1'b0;
        for (int w = 0; w < WAYS; w++) d[w*BITS +: BITS] = BITS'(256 + w);
        d[2*BITS +: BITS] = 9'd2;
        d[5*BITS +: BITS] = 9'h1FE;
        exp_frame = d;
        exp_frame[2*BITS +: BITS] = 9'd0;
        exp_frame[5*BITS +: BITS] = 9'h1FF;
        applyStimulus('1, d, 1'b0, 1'b0);
        checkOutput("t6_frame", out_data, exp_frame);
        // Write and capture to the same way together: old offset applies
        ofs_we = 1'b1; ofs_addr = 3'd0; ofs_wdata = 10'd7;
        for (int w = 0; w < WAYS; w++) d[w*BITS +: BITS] = 9'h030;
        applyStimulus('1, d, 1'b0, 1'b0);
        ofs_we = 1'b0;
        applyStimulus('0, rand_word(), 1'b1, 1'b0);
        checkOutput("t6_old_ofs", DW'(out_data[0 +: BITS]), DW'(9'h030));
        checkOutput("t6_way2",    DW'(out_data[2*BITS +: BITS]), DW'(9'h02B));
        checkOutput("t6_way5",    DW'(out_data[5*BITS +: BITS]), DW'(9'h033));
`endif

        // Randomised traffic against the model
        tag = "rand";
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [WAYS-1:0] dn;
            for (int w = 0; w < WAYS; w++) dn[w] = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
`ifdef TI_COLLECT_OFFSET_EN
            ofs_we    = ($urandom_range(0, 9) == 0);
            ofs_addr  = 3'($urandom());
            ofs_wdata = 10'($urandom());
`endif
            applyStimulus(dn, rand_word(), 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
